// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RISC-V IF stage: fetch FSM states, NOP encoding
// and the default datapath width.
package fetch_stage_pkg;

   localparam int          XLEN_DEF  = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      KILL  = 2'd2,
      HOLD  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush clears valid and forces a NOP, load captures
// a new instruction, otherwise the contents are held (stall).
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            flush,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] pc_plus4_in,
   input  logic [31:0]     instr_in,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4,
   output logic [31:0]     id_instr
);

   logic            valid_q, valid_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc4_q, pc4_d;
   logic [31:0]     instr_q, instr_d;

   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      instr_d = instr_q;
      if (flush) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (load) begin
         valid_d = 1'b1;
         pc_d    = pc_in;
         pc4_d   = pc_plus4_in;
         instr_d = instr_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         pc4_q   <= '0;
         instr_q <= NOP_INSTR;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         instr_q <= instr_d;
      end
   end

   assign id_valid    = valid_q;
   assign id_pc       = pc_q;
   assign id_pc_plus4 = pc4_q;
   assign id_instr    = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one instruction-memory request at a time and
// feeds the IF/ID register. Optional macro MISALIGN_CHECK_EN enables fetch_fault.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [31:0]     imem_rdata,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4,
   output logic [31:0]     id_instr,
   output logic            fetch_fault
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] target_pc;
   logic [31:0]     hold_q, hold_d;
   logic            fault;
   logic            load, flush, hold_en;
   logic [31:0]     load_instr;

   // PC+4 as a ripple-carry chain with carry-in 0; wraps modulo 2^XLEN
   always_comb begin
      logic c;
      c        = 1'b0;
      pc_plus4 = '0;
      for (int i = 0; i < XLEN; i++) begin
         pc_plus4[i] = pc_q[i] ^ PC_STEP[i] ^ c;
         c           = (pc_q[i] & PC_STEP[i]) | (c & (pc_q[i] ^ PC_STEP[i]));
      end
   end

`ifdef MISALIGN_CHECK_EN
   logic fault_q, fault_d;

   always_comb fault_d = fault_q | (redirect & (redirect_pc[1:0] != 2'b00));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fault_q <= 1'b0;
      else        fault_q <= fault_d;
   end

   assign target_pc = redirect_pc;
   assign fault     = fault_q;
`else
   assign target_pc = redirect_pc & ~XLEN'(3);
   assign fault     = 1'b0;
`endif

   assign fetch_fault = fault;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= BOOT;
      else        state_q <= state_d;
   end

   // A redirect with a response still in flight must wait to discard it (KILL)
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT:  state_d = FETCH;
         FETCH: begin
            if (redirect)                 state_d = imem_valid ? FETCH : KILL;
            else if (imem_valid && !fault) state_d = stall ? HOLD : FETCH;
         end
         KILL:  if (imem_valid)           state_d = FETCH;
         HOLD:  if (redirect || !stall)   state_d = FETCH;
         default:                         state_d = BOOT;
      endcase
   end

   always_comb begin
      imem_req   = (state_q == FETCH) && !fault;
      load       = 1'b0;
      hold_en    = 1'b0;
      load_instr = imem_rdata;
      if (!redirect && !fault) begin
         if (state_q == FETCH && imem_valid) begin
            load    = !stall;
            hold_en = stall;
         end else if (state_q == HOLD && !stall) begin
            load       = 1'b1;
            load_instr = hold_q;
         end
      end
      flush = redirect | fault | (!stall & !load);
   end

   always_comb begin
      pc_d   = pc_q;
      hold_d = hold_q;
      if (redirect)  pc_d = target_pc;
      else if (load) pc_d = pc_plus4;
      if (hold_en)   hold_d = imem_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

   assign imem_addr = pc_q;

   if_id_reg #(.XLEN(XLEN)) u_if_id_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .flush       (flush),
      .pc_in       (pc_q),
      .pc_plus4_in (pc_plus4),
      .instr_in    (load_instr),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_pc_plus4 (id_pc_plus4),
      .id_instr    (id_instr)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall/hold, redirect kill,
// redirect+stall, PC wrap, misaligned redirect and reset mid-fetch.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_instr;
   logic        fetch_fault;

   int checks = 0;
   int failures = 0;

   fetch_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_valid  (imem_valid),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_pc_plus4 (id_pc_plus4),
      .id_instr    (id_instr),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   // Apply one cycle of inputs, then sample 1 time unit after the rising edge
   task automatic step(input logic s, input logic r, input logic [31:0] rpc,
                       input logic v, input logic [31:0] d);
      stall       = s;
      redirect    = r;
      redirect_pc = rpc;
      imem_valid  = v;
      imem_rdata  = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("rst_req",    imem_req,    0);
      chk("rst_addr",   imem_addr,   0);
      chk("rst_valid",  id_valid,    0);
      chk("rst_pc",     id_pc,       0);
      chk("rst_pc4",    id_pc_plus4, 0);
      chk("rst_instr",  id_instr,    NOP_INSTR);
      chk("rst_fault",  fetch_fault, 0);

      rst_n = 1'b1;
      step(0, 0, 0, 0, 0);
      chk("boot_req",  imem_req,  1);
      chk("boot_addr", imem_addr, 0);

      for (int i = 0; i < 2; i++) begin
         a = 32'(i * 4);
         chk("seq_addr",  imem_addr, a);
         chk("seq_req",   imem_req,  1);
         step(0, 0, 0, 1, word(a));
         chk("seq_valid", id_valid,    1);
         chk("seq_pc",    id_pc,       a);
         chk("seq_pc4",   id_pc_plus4, a + 4);
         chk("seq_instr", id_instr,    word(a));
         step(0, 0, 0, 0, 0);
         chk("seq_bubble",    id_valid, 0);
         chk("seq_bubble_in", id_instr, NOP_INSTR);
      end

      chk("seq_addr8", imem_addr, 32'h8);
      step(0, 0, 0, 1, word(32'h8));
      chk("cap8_pc",   id_pc,     32'h8);
      chk("cap8_addr", imem_addr, 32'hC);

      step(1, 0, 0, 0, 0);
      chk("stall_wait_valid", id_valid, 1);
      chk("stall_wait_pc",    id_pc,    32'h8);
      chk("stall_wait_req",   imem_req, 1);
      step(1, 0, 0, 1, word(32'hC));
      chk("hold_req",  imem_req,  0);
      chk("hold_pc",   id_pc,     32'h8);
      chk("hold_addr", imem_addr, 32'hC);
      step(1, 0, 0, 0, 0);
      chk("hold2_req",   imem_req, 0);
      chk("hold2_instr", id_instr, word(32'h8));
      step(0, 0, 0, 0, 0);
      chk("resume_pc",    id_pc,     32'hC);
      chk("resume_instr", id_instr,  word(32'hC));
      chk("resume_valid", id_valid,  1);
      chk("resume_addr",  imem_addr, 32'h10);
      chk("resume_req",   imem_req,  1);

      step(0, 1, 32'h100, 0, 0);
      chk("kill_valid", id_valid,  0);
      chk("kill_instr", id_instr,  NOP_INSTR);
      chk("kill_addr",  imem_addr, 32'h100);
      chk("kill_req",   imem_req,  0);
      step(0, 0, 0, 1, word(32'h10));
      chk("stale_valid", id_valid,  0);
      chk("stale_req",   imem_req,  1);
      chk("stale_addr",  imem_addr, 32'h100);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, word(32'h100));
      chk("redir_pc",    id_pc,    32'h100);
      chk("redir_valid", id_valid, 1);
      chk("redir_instr", id_instr, word(32'h100));

      step(1, 1, 32'h200, 1, word(32'h104));
      chk("rs_valid", id_valid,  0);
      chk("rs_instr", id_instr,  NOP_INSTR);
      chk("rs_addr",  imem_addr, 32'h200);
      chk("rs_req",   imem_req,  1);

      step(0, 1, 32'hFFFF_FFFC, 1, word(32'h200));
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      step(0, 0, 0, 1, word(32'hFFFF_FFFC));
      chk("wrap_pc",    id_pc,       32'hFFFF_FFFC);
      chk("wrap_pc4",   id_pc_plus4, 32'h0);
      chk("wrap_naddr", imem_addr,   32'h0);

      step(0, 1, 32'h102, 0, 0);
`ifdef MISALIGN_CHECK_EN
      chk("mis_fault", fetch_fault, 1);
      chk("mis_req",   imem_req,    0);
      chk("mis_valid", id_valid,    0);
`else
      chk("mis_addr",  imem_addr,   32'h100);
      chk("mis_fault", fetch_fault, 0);
`endif

      rst_n = 1'b0;
      #1;
      chk("arst_req",   imem_req,  0);
      chk("arst_addr",  imem_addr, 0);
      chk("arst_valid", id_valid,  0);
      rst_n = 1'b1;
      step(0, 0, 0, 1, word(32'h100));
      chk("late_valid", id_valid,    0);
      chk("late_req",   imem_req,    1);
      chk("late_addr",  imem_addr,   0);
      chk("late_fault", fetch_fault, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
